// File: rtl/div_period_meter_pkg.sv
// div_period_meter_pkg: shared FSM state encoding and default counter width
package div_period_meter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEASURE = 2'd2} state_e;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/div_period_meter_if.sv
// div_period_meter_if: stimulus and measurement results of the period meter
interface div_period_meter_if #(parameter int CNT_W = 16);
  logic             sig_in;
  logic             meas_en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             ovf;
  logic             busy;
  modport master (output sig_in, meas_en, input period, high_time, meas_valid, ovf, busy);
  modport slave  (input sig_in, meas_en, output period, high_time, meas_valid, ovf, busy);
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: optional synchronizer chain plus rising-edge detector
module sync_edge_det #(parameter int SYNC_STAGES = 2) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);
  logic s_d_q;
  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s_o = d_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else begin
          sync_q[0] <= d_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s_o = sync_q[SYNC_STAGES-1];
    end
  endgenerate
  always_ff @(posedge clk) s_d_q <= rst ? 1'b0 : s_o;
  assign rise_o = s_o & ~s_d_q;
endmodule

// File: rtl/div_period_meter.sv
// div_period_meter: measures rise-to-rise period and high time of sig_in in sys_clk cycles
module div_period_meter
  import div_period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic              sys_clk,
  input logic              sys_rst,
  div_period_meter_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX = '1;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d, period_q, period_d, high_q, high_d;
  logic             sat_q, sat_d, ovf_q, ovf_d, valid_q, valid_d, s, rise;
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(sys_clk), .rst(sys_rst), .d_i(bus.sig_in), .s_o(s), .rise_o(rise)
  );
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      sat_q    <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      sat_q    <= sat_d;
      period_q <= period_d;
      high_q   <= high_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end
  // meas_en dropping takes priority over a coincident rise
  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    sat_d    = sat_q;
    period_d = period_q;
    high_d   = high_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    if (state_q != IDLE && !bus.meas_en) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
      sat_d   = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = bus.meas_en ? ARM : IDLE;
    end else if (rise) begin
      if (state_q == MEASURE) begin
        period_d = per_q;
        high_d   = hi_q;
        ovf_d    = sat_q;
        valid_d  = 1'b1;
      end
      state_d = MEASURE;
      per_d   = {{(CNT_W-1){1'b0}}, 1'b1};
      hi_d    = {{(CNT_W-1){1'b0}}, 1'b1};
      sat_d   = 1'b0;
    end else if (state_q == MEASURE) begin
      per_d = (per_q == MAX) ? MAX : per_q + 1'b1;
      hi_d  = (hi_q == MAX || !s) ? hi_q : hi_q + 1'b1;
      sat_d = sat_q | (per_q == MAX) | (s & (hi_q == MAX));
    end
  end
  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.ovf        = ovf_q;
  assign bus.meas_valid = valid_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_div_period_meter.sv
// tb_div_period_meter: random and directed stimulus on 16-bit and 4-bit meters, scoreboard checked
module tb_div_period_meter;
  typedef struct {int per; int hi; bit ovf;} res_t;
  logic clk = 1'b0, rst = 1'b1, sig = 1'b0, en = 1'b0;
  int n_chk = 0, n_fail = 0;
  res_t q0[$], q1[$];
  int exp_per[2], exp_hi[2];
  bit exp_ovf[2];
  bit exp_valid = 0, exp_busy = 0, rise_next = 0;
  int mode = 0, start = 0, cyc = 0;
  bit sy0 = 0, sy1 = 0, sdm = 0;
  bit s_log[0:99999];

  div_period_meter_if #(.CNT_W(16)) if16 ();
  div_period_meter_if #(.CNT_W(4))  if4 ();
  assign if16.sig_in = sig;
  assign if16.meas_en = en;
  assign if4.sig_in = sig;
  assign if4.meas_en = en;
  div_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (.sys_clk(clk), .sys_rst(rst), .bus(if16.slave));
  div_period_meter #(.CNT_W(4),  .SYNC_STAGES(2)) dut4  (.sys_clk(clk), .sys_rst(rst), .bus(if4.slave));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // reference: a result is the span between consecutive detected rises, clipped to the counter width
  always @(posedge clk) begin
    bit rise;
    int p, h, mx;
    res_t r;
    rise = sy1 & ~sdm;
    s_log[cyc] = sy1;
    exp_valid = 0;
    if (rst) begin
      mode = 0;
      for (int w = 0; w < 2; w++) begin exp_per[w] = 0; exp_hi[w] = 0; exp_ovf[w] = 0; end
      sy0 = 0; sy1 = 0; sdm = 0;
    end else begin
      if (mode == 0) begin
        if (en) mode = 1;
      end else if (!en) mode = 0;
      else if (rise) begin
        if (mode == 2) begin
          p = cyc - start;
          h = 0;
          for (int k = start; k < cyc; k++) h += int'(s_log[k]);
          for (int w = 0; w < 2; w++) begin
            mx = (w == 0) ? 65535 : 15;
            r.per = (p > mx) ? mx : p;
            r.hi = (h > mx) ? mx : h;
            r.ovf = p > mx;
            exp_per[w] = r.per; exp_hi[w] = r.hi; exp_ovf[w] = r.ovf;
            if (w == 0) q0.push_back(r); else q1.push_back(r);
          end
          exp_valid = 1;
        end
        mode = 2;
        start = cyc;
      end
      sdm = sy1; sy1 = sy0; sy0 = sig;
    end
    exp_busy = mode != 0;
    cyc++;
    rise_next = sy1 & ~sdm;
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    res_t r;
    chk("valid16", int'(if16.meas_valid), int'(exp_valid));
    chk("valid4", int'(if4.meas_valid), int'(exp_valid));
    chk("busy16", int'(if16.busy), int'(exp_busy));
    chk("busy4", int'(if4.busy), int'(exp_busy));
    chk("period16", int'(if16.period), exp_per[0]);
    chk("high16", int'(if16.high_time), exp_hi[0]);
    chk("ovf16", int'(if16.ovf), int'(exp_ovf[0]));
    chk("period4", int'(if4.period), exp_per[1]);
    chk("high4", int'(if4.high_time), exp_hi[1]);
    chk("ovf4", int'(if4.ovf), int'(exp_ovf[1]));
    if (if16.meas_valid) begin
      if (q0.size() == 0) chk("q16_nonempty", 0, 1);
      else begin
        r = q0.pop_front();
        chk("sb_period16", int'(if16.period), r.per);
        chk("sb_high16", int'(if16.high_time), r.hi);
        chk("sb_ovf16", int'(if16.ovf), int'(r.ovf));
      end
    end
    if (if4.meas_valid) begin
      if (q1.size() == 0) chk("q4_nonempty", 0, 1);
      else begin
        r = q1.pop_front();
        chk("sb_period4", int'(if4.period), r.per);
        chk("sb_high4", int'(if4.high_time), r.hi);
        chk("sb_ovf4", int'(if4.ovf), int'(r.ovf));
      end
    end
  end

  task automatic step(input bit s_, input bit e_);
    @(negedge clk);
    sig = s_;
    en = e_;
    rst = 1'b0;
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < hi + lo; i++) step(i < hi, en);
  endtask

  task automatic drop_on_rise();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (rise_next && mode == 2) begin en = 1'b0; done = 1; end
      else sig = (i % 10) < 5;
    end
    if (!done) chk("drop_on_rise_found", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(0, 1);
    wave(1, 6, 10);
    wave(5, 5, 6);
    wave(3, 9, 5);
    wave(2, 18, 5);
    wave(2, 6, 6);
    @(negedge clk); rst = 1'b1;
    wave(5, 5, 4);
    drop_on_rise();
    wave(2, 3, 3);
    step(0, 1);
    wave(4, 4, 4);
    for (int i = 0; i < 3; i++) step(1, 1);
    step(1, 0);
    wave(1, 2, 3);
    step(1, 1);
    for (int i = 0; i < 100; i++) step(1, 1);
    for (int i = 0; i < 5; i++) step(0, 1);
    wave(3, 3, 4);
    repeat (40) begin
      int hi, lo, reps;
      hi = $urandom_range(1, 6);
      lo = $urandom_range(1, 20);
      reps = $urandom_range(2, 5);
      for (int r = 0; r < reps; r++)
        for (int i = 0; i < hi + lo; i++) begin
          @(negedge clk);
          sig = i < hi;
          rst = ($urandom_range(0, 400) == 0);
          if ($urandom_range(0, 60) == 0) en = ~en;
        end
    end
    step(0, 0);
    repeat (6) step(0, 0);
    chk("q16_empty", q0.size(), 0);
    chk("q4_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
